// File: rtl/dm_arb_pkg.sv
// -----------------------------------------------------------------------------
// dm_arb_pkg
// Shared types and helpers for the data-memory port arbiter:
//   state_t     - sequencer states (IDLE accepting, MERGE finishing a partial write)
//   BE_FULL     - byte-enable pattern for a whole-word write
//   P_CPU/P_LOAD- requester port indices
//   byte_merge  - per-byte select between new write data and old memory data
// -----------------------------------------------------------------------------
package dm_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        MERGE = 1'b1
    } state_t;

    localparam logic [3:0] BE_FULL = 4'hF;
    localparam int         P_CPU   = 0;
    localparam int         P_LOAD  = 1;

    // Byte i of the result comes from i_new when i_be[i] is set, else from i_old.
    function automatic logic [31:0] byte_merge(input logic [31:0] i_old,
                                               input logic [31:0] i_new,
                                               input logic [3:0]  i_be);
        logic [31:0] w_res;
        for (int b = 0; b < 4; b++) begin
            w_res[8*b +: 8] = i_be[b] ? i_new[8*b +: 8] : i_old[8*b +: 8];
        end
        return w_res;
    endfunction

endpackage

// File: rtl/dm_rr_arb2.sv
// -----------------------------------------------------------------------------
// dm_rr_arb2
// Two-input round-robin grant logic. A lone requester always wins; under
// contention the port named by the pointer wins and the pointer moves to the
// loser, so contending ports alternate.
// Ports:
//   clk, reset - clock, asynchronous active-high reset (pointer -> 0)
//   i_en       - grants allowed this cycle
//   i_req[1:0] - request per port
//   o_gnt[1:0] - one-hot (or zero) combinational grant
// -----------------------------------------------------------------------------
module dm_rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    logic       r_ptr;
    logic [1:0] w_gnt;

    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_gnt = 2'b00;
        if (i_en) begin
            if (i_req == 2'b11) begin
                w_gnt[r_ptr] = 1'b1;
            end else begin
                w_gnt = i_req;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= 1'b0;
        end else if (i_en && (i_req == 2'b11)) begin
            r_ptr <= ~r_ptr;
        end
    end

    assign o_gnt = w_gnt;

endmodule

// File: rtl/dm_port_arbiter.sv
// -----------------------------------------------------------------------------
// dm_port_arbiter
// Arbitrates the CPU load/store port (m0) and the loader port (m1) onto one
// word-organised data memory. One access is granted per cycle; partial
// (byte-enable) writes take an extra MERGE cycle as read-modify-write.
// Responses are registered and appear one cycle after the access completes.
// Ports:
//   clk, reset                - clock, asynchronous active-high reset
//   mX_req/we/addr/wdata/be   - request from port X (held until mX_gnt)
//   mX_gnt                    - combinational accept
//   mX_rvalid/rdata/err       - registered response pulse to port X
//   mem_idx/we/wdata          - word index, write strobe and data to memory
//   mem_rdata                 - combinational read of RAM[mem_idx]
// -----------------------------------------------------------------------------
module dm_port_arbiter
    import dm_arb_pkg::*;
#(
    parameter int DEPTH_WORDS = 3072,
    parameter int IDX_W       = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             m0_req,
    input  logic             m0_we,
    input  logic [31:0]      m0_addr,
    input  logic [31:0]      m0_wdata,
    input  logic [3:0]       m0_be,
    output logic             m0_gnt,
    output logic             m0_rvalid,
    output logic [31:0]      m0_rdata,
    output logic             m0_err,
    input  logic             m1_req,
    input  logic             m1_we,
    input  logic [31:0]      m1_addr,
    input  logic [31:0]      m1_wdata,
    input  logic [3:0]       m1_be,
    output logic             m1_gnt,
    output logic             m1_rvalid,
    output logic [31:0]      m1_rdata,
    output logic             m1_err,
    output logic [IDX_W-1:0] mem_idx,
    output logic             mem_we,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata
);

    state_t r_state, w_state_nx;

    // Registered response, shared by both ports and steered by r_rvalid.
    logic [1:0]  r_rvalid;
    logic [31:0] r_rdata;
    logic        r_err;

    // Pending partial write captured in the accept cycle.
    logic [IDX_W-1:0] r_idx;
    logic [31:0]      r_wdata;
    logic [31:0]      r_old;
    logic [3:0]       r_be;
    logic             r_win;

    logic [1:0]       w_req, w_gnt;
    logic             w_en, w_win, w_we, w_oob, w_latch;
    logic [29:0]      w_word;
    logic [31:0]      w_wdata;
    logic [3:0]       w_be;
    logic [IDX_W-1:0] w_mem_idx;
    logic             w_mem_we;
    logic [31:0]      w_mem_wdata;
    logic [1:0]       w_rsp_valid;
    logic [31:0]      w_rsp_rdata;
    logic             w_rsp_err;
    logic             w_unused_addr_lsbs;

    assign w_unused_addr_lsbs = ^{m0_addr[1:0], m1_addr[1:0]};

    assign w_req = {m1_req, m0_req};
    // No grants while merging, and none while reset is held.
    assign w_en  = (r_state == IDLE) && !reset;

    dm_rr_arb2 u_rr (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_en),
        .i_req (w_req),
        .o_gnt (w_gnt)
    );

    // Winner's request fields.
    assign w_win   = w_gnt[P_LOAD];
    assign w_we    = w_win ? m1_we         : m0_we;
    assign w_word  = w_win ? m1_addr[31:2] : m0_addr[31:2];
    assign w_wdata = w_win ? m1_wdata      : m0_wdata;
    assign w_be    = w_win ? m1_be         : m0_be;
    assign w_oob   = (w_word >= 30'(DEPTH_WORDS));

    always_comb begin
        w_state_nx  = r_state;
        w_mem_idx   = '0;
        w_mem_we    = 1'b0;
        w_mem_wdata = '0;
        w_rsp_valid = 2'b00;
        w_rsp_rdata = '0;
        w_rsp_err   = 1'b0;
        w_latch     = 1'b0;
        case (r_state)
            IDLE: begin
                if (|w_gnt) begin
                    w_rsp_valid = w_gnt;
                    if (w_oob) begin
                        w_rsp_err = 1'b1;
                    end else begin
                        // Index drives the read port for loads and for the
                        // old-data capture of a partial write.
                        w_mem_idx = w_word[IDX_W-1:0];
                        if (!w_we) begin
                            w_rsp_rdata = mem_rdata;
                        end else if (w_be == BE_FULL) begin
                            w_mem_we    = 1'b1;
                            w_mem_wdata = w_wdata;
                        end else if (w_be != 4'h0) begin
                            // Response deferred until the merged word is written.
                            w_rsp_valid = 2'b00;
                            w_latch     = 1'b1;
                            w_state_nx  = MERGE;
                        end
                    end
                end
            end
            MERGE: begin
                w_mem_idx          = r_idx;
                w_mem_we           = 1'b1;
                w_mem_wdata        = byte_merge(r_old, r_wdata, r_be);
                w_rsp_valid[r_win] = 1'b1;
                w_state_nx         = IDLE;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_rvalid <= 2'b00;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_rvalid <= w_rsp_valid;
            r_rdata  <= w_rsp_rdata;
            r_err    <= w_rsp_err;
        end
    end

    // NOTE: the partial-write holding registers have no reset: they are only
    // read in MERGE, which is reachable solely through a cycle that loads them.
    always_ff @(posedge clk) begin
        if (w_latch) begin
            r_idx   <= w_word[IDX_W-1:0];
            r_wdata <= w_wdata;
            r_old   <= mem_rdata;
            r_be    <= w_be;
            r_win   <= w_win;
        end
    end

    assign m0_gnt    = w_gnt[P_CPU];
    assign m1_gnt    = w_gnt[P_LOAD];
    assign m0_rvalid = r_rvalid[P_CPU];
    assign m1_rvalid = r_rvalid[P_LOAD];
    assign m0_rdata  = r_rvalid[P_CPU]  ? r_rdata : 32'h0;
    assign m1_rdata  = r_rvalid[P_LOAD] ? r_rdata : 32'h0;
    assign m0_err    = r_rvalid[P_CPU]  & r_err;
    assign m1_err    = r_rvalid[P_LOAD] & r_err;

    assign mem_idx   = w_mem_idx;
    assign mem_we    = w_mem_we;
    assign mem_wdata = w_mem_wdata;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dm_port_arbiter
// Bench for dm_port_arbiter: a RAM attached to the memory port, a
// transaction-level reference model (reference memory, round-robin pointer,
// one pending merge) compared against the DUT every cycle, directed scenarios
// with literal expectations, then randomized traffic on both ports.
// -----------------------------------------------------------------------------
module tb_dm_port_arbiter;

    localparam int DEPTH = 3072;
    localparam int IDX_W = 12;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req   = '0;
    logic [1:0]  we    = '0;
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [3:0]  be    [2];
    logic [1:0]  gnt, rvalid, err;
    logic [31:0] rdata [2];
    logic [IDX_W-1:0] mem_idx;
    logic        mem_we;
    logic [31:0] mem_wdata, mem_rdata;

    logic [31:0] ram [DEPTH];

    dm_port_arbiter #(.DEPTH_WORDS(DEPTH), .IDX_W(IDX_W)) dut (
        .clk(clk), .reset(reset),
        .m0_req(req[0]), .m0_we(we[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]), .m0_be(be[0]),
        .m0_gnt(gnt[0]), .m0_rvalid(rvalid[0]), .m0_rdata(rdata[0]), .m0_err(err[0]),
        .m1_req(req[1]), .m1_we(we[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]), .m1_be(be[1]),
        .m1_gnt(gnt[1]), .m1_rvalid(rvalid[1]), .m1_rdata(rdata[1]), .m1_err(err[1]),
        .mem_idx(mem_idx), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory attached to the DUT: combinational read, write at the clock edge.
    assign mem_rdata = (int'(mem_idx) < DEPTH) ? ram[mem_idx] : 32'h0;
    always @(posedge clk) begin
        if (mem_we && (int'(mem_idx) < DEPTH)) ram[mem_idx] <= mem_wdata;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    logic [31:0] ref_mem [DEPTH];
    int          m_ptr;
    bit          mp_pend;
    int          mp_win, mp_idx;
    logic [31:0] mp_wdata;
    logic [3:0]  mp_be;

    // Values observed in the most recent cycle() call.
    logic [1:0]  obs_gnt, obs_rv, obs_err;
    logic        obs_we;
    logic [31:0] obs_wdata;
    logic [31:0] obs_rdata [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge_ref(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] en);
        logic [31:0] res = old_w;
        for (int b = 0; b < 4; b++) if (en[b]) res[8*b +: 8] = new_w[8*b +: 8];
        return res;
    endfunction

    // One clock cycle, entered just after an edge with inputs already driven:
    // checks the combinational outputs against the model, steps the model,
    // crosses the edge and checks the registered response.
    task automatic cycle();
        logic [1:0]  xg, nrv;
        logic        xwe, chk_idx, nerr;
        int          xidx, w, idx;
        logic [31:0] xwd, nrd;
        #1;
        xg = '0; nrv = '0; xwe = 1'b0; chk_idx = 1'b0; nerr = 1'b0;
        xidx = 0; xwd = '0; nrd = '0;
        if (mp_pend) begin
            xwe = 1'b1; chk_idx = 1'b1; xidx = mp_idx;
            xwd = merge_ref(ref_mem[mp_idx], mp_wdata, mp_be);
            ref_mem[mp_idx] = xwd;
            nrv[mp_win] = 1'b1;
            mp_pend = 1'b0;
        end else if (req != 2'b00) begin
            if (req == 2'b11) begin
                w = m_ptr; m_ptr = 1 - w;
            end else begin
                w = req[1] ? 1 : 0;
            end
            xg[w] = 1'b1; nrv[w] = 1'b1;
            idx = int'(addr[w] >> 2);
            if (idx >= DEPTH) begin
                nerr = 1'b1;
            end else if (!we[w]) begin
                nrd = ref_mem[idx]; xidx = idx; chk_idx = 1'b1;
            end else if (be[w] == 4'hF) begin
                xwe = 1'b1; xwd = wdata[w]; xidx = idx; chk_idx = 1'b1;
                ref_mem[idx] = wdata[w];
            end else if (be[w] != 4'h0) begin
                nrv = '0; xidx = idx; chk_idx = 1'b1;
                mp_pend = 1'b1; mp_win = w; mp_idx = idx; mp_wdata = wdata[w]; mp_be = be[w];
            end
        end
        chk("gnt", 32'(gnt), 32'(xg));
        chk("mem_we", 32'(mem_we), 32'(xwe));
        if (xwe) chk("mem_wdata", mem_wdata, xwd);
        if (chk_idx) chk("mem_idx", 32'(mem_idx), 32'(xidx));
        obs_gnt = gnt; obs_we = mem_we; obs_wdata = mem_wdata;
        @(posedge clk);
        #1;
        chk("rvalid", 32'(rvalid), 32'(nrv));
        for (int p = 0; p < 2; p++) begin
            if (nrv[p]) begin
                chk($sformatf("rdata%0d", p), rdata[p], nrd);
                chk($sformatf("err%0d", p), 32'(err[p]), 32'(nerr));
            end
        end
        obs_rv = rvalid; obs_err = err; obs_rdata[0] = rdata[0]; obs_rdata[1] = rdata[1];
    endtask

    task automatic model_reset();
        m_ptr = 0; mp_pend = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 32'h0);
        chk({tag, "_rvalid"}, 32'(rvalid), 32'h0);
        chk({tag, "_err"}, 32'(err), 32'h0);
        chk({tag, "_rdata0"}, rdata[0], 32'h0);
        chk({tag, "_rdata1"}, rdata[1], 32'h0);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'h0);
        chk({tag, "_mem_idx"}, 32'(mem_idx), 32'h0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_reset_values("rst");
        reset = 1'b0;
    endtask

    task automatic drive(input int p, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] b);
        req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d; be[p] = b;
    endtask

    task automatic new_req(input int p);
        int sel;
        logic [31:0] a;
        sel = int'($urandom_range(0, 9));
        if (sel == 0)      a = 32'($urandom_range(DEPTH, DEPTH + 8)) << 2;
        else if (sel == 1) a = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        else               a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
        sel = int'($urandom_range(0, 3));
        drive(p, 1'($urandom_range(0, 1)), a, $urandom,
              (sel == 0) ? 4'hF : (sel == 1) ? 4'h0 : 4'($urandom_range(0, 15)));
    endtask

    initial begin
        logic [31:0] v;
        for (int i = 0; i < DEPTH; i++) begin
            v = (i == 4) ? 32'h1234_5678 : ((i == 5) || (i == 6)) ? 32'h1122_3344 : $urandom;
            ram[i] <= v;
            ref_mem[i] = v;
        end
        for (int p = 0; p < 2; p++) begin
            addr[p] = '0; wdata[p] = '0; be[p] = '0;
        end
        model_reset();

        // Contention straight out of reset: strict alternation P0,P1,P0,P1.
        do_reset();
        drive(0, 1'b0, 32'h10, 32'h0, 4'h0);
        drive(1, 1'b0, 32'h14, 32'h0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("rr_order", 32'(obs_gnt), (i % 2 == 0) ? 32'h1 : 32'h2);
            chk("rr_one_rvalid", 32'($countones(obs_rv)), 32'h1);
        end
        req = '0;

        // Simple read of word 4.
        do_reset();
        drive(0, 1'b0, 32'h10, 32'h0, 4'h0);
        cycle();
        chk("rd_gnt", 32'(obs_gnt), 32'h1);
        chk("rd_rvalid", 32'(obs_rv), 32'h1);
        chk("rd_data", obs_rdata[0], 32'h1234_5678);
        chk("rd_err", 32'(obs_err), 32'h0);

        // Partial write from m1 to word 6; m0 waits during MERGE, then reads it.
        req = '0;
        drive(1, 1'b1, 32'h18, 32'h0000_AB00, 4'b0010);
        cycle();
        chk("pw_gnt", 32'(obs_gnt), 32'h2);
        chk("pw_no_early_rv", 32'(obs_rv), 32'h0);
        req[1] = 1'b0;
        drive(0, 1'b0, 32'h18, 32'h0, 4'h0);
        cycle();
        chk("pw_merge_gnt", 32'(obs_gnt), 32'h0);
        chk("pw_merge_we", 32'(obs_we), 32'h1);
        chk("pw_merge_wdata", obs_wdata, 32'h1122_AB44);
        chk("pw_rvalid", 32'(obs_rv), 32'h2);
        cycle();
        chk("pw_rd_gnt", 32'(obs_gnt), 32'h1);
        chk("pw_rd_data", obs_rdata[0], 32'h1122_AB44);

        // Out-of-range read at index 3072.
        drive(0, 1'b0, 32'h3000, 32'h0, 4'h0);
        cycle();
        chk("oob_we", 32'(obs_we), 32'h0);
        chk("oob_rvalid", 32'(obs_rv), 32'h1);
        chk("oob_err", 32'(obs_err), 32'h1);
        chk("oob_rdata", obs_rdata[0], 32'h0);

        // Full write then back-to-back read of the same word.
        drive(0, 1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF);
        cycle();
        chk("fw_we", 32'(obs_we), 32'h1);
        drive(0, 1'b0, 32'h40, 32'h0, 4'h0);
        cycle();
        chk("raw_data", obs_rdata[0], 32'hDEAD_BEEF);
        req = '0;

        // Reset asserted while a partial write to word 5 is in MERGE.
        drive(1, 1'b1, 32'h14, 32'hFFFF_FFFF, 4'b0101);
        cycle();
        chk("rm_gnt", 32'(obs_gnt), 32'h2);
        req = '0;
        #1;
        chk("rm_in_merge", 32'(mem_we), 32'h1);
        reset = 1'b1;
        model_reset();
        #1;
        check_reset_values("rm_async");
        @(posedge clk);
        #1;
        check_reset_values("rm_held");
        chk("rm_mem_kept", ram[5], 32'h1122_3344);
        reset = 1'b0;
        drive(0, 1'b0, 32'h14, 32'h0, 4'h0);
        cycle();
        chk("rm_next_gnt", 32'(obs_gnt), 32'h1);
        chk("rm_next_data", obs_rdata[0], 32'h1122_3344);
        req = '0;

        // Randomized traffic, including occasional withdrawals.
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (req[p] && !obs_gnt[p] && ($urandom_range(0, 19) == 0)) begin
                    req[p] = 1'b0;
                end else if (!req[p] || obs_gnt[p]) begin
                    if ($urandom_range(0, 3) != 0) new_req(p);
                    else req[p] = 1'b0;
                end
            end
            cycle();
        end
        req = '0;
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
